// File: rtl/fetch_pc_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_pc_ctrl
//
// IF-stage sequencer. Steers the external pc_counter register (pc_next/pc_en),
// drives a single-outstanding instruction-memory request port, and holds the
// most recently returned instruction in a one-entry buffer for decode.
// Redirects and traps reload the PC, flush the buffer and, when a request is
// still in flight, arm a KILL state that drops the wrong-path response.
//
// Parameters
//   RESET_VEC        first fetch address loaded into the PC after reset
//   TRAP_VEC         PC loaded when trap_valid is seen
//
// Ports
//   clk              clock, all state updates on posedge
//   reset            synchronous, active-high reset
//   pc               current PC from pc_counter
//   pc_next          next PC value presented to pc_counter
//   pc_en            PC load enable to pc_counter
//   imem_req         instruction fetch request
//   imem_addr        fetch address (equals pc while imem_req is high)
//   imem_gnt         request accepted this cycle
//   imem_rvalid      read data valid (at least one cycle after gnt)
//   imem_rdata       returned instruction word
//   if_valid         if_instr/if_pc hold a valid instruction
//   if_instr         buffered instruction
//   if_pc            address of the buffered instruction
//   if_ready         decode consumes the buffer this cycle
//   redirect_valid   taken branch/jump, one-cycle pulse
//   redirect_target  new PC for a redirect
//   trap_valid       trap/exception, one-cycle pulse, wins over redirect
// -----------------------------------------------------------------------------
module fetch_pc_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] pc_next,
   output logic        pc_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        trap_valid
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      KILL = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t      state_reg;
   state_t      state_next;
   logic        if_valid_reg;
   logic        if_valid_next;
   logic [31:0] if_instr_reg;
   logic [31:0] if_instr_next;
   logic [31:0] if_pc_reg;
   logic [31:0] if_pc_next;
   // Address of the request currently in flight; tags the returned word.
   logic [31:0] req_pc_reg;
   logic [31:0] req_pc_next;

   // ---------------------------------------------------------------------------
   // Helper terms
   // ---------------------------------------------------------------------------
   logic [31:0] pc_plus4;
   logic        consume;
   logic        flush;
   logic        buf_free;

   assign pc_plus4 = pc + 32'd4;
   assign consume  = if_valid_reg && if_ready;
   // The buffer can accept a new word once the current one is gone or is
   // leaving this cycle; this is what keeps a load from ever overwriting
   // valid, unconsumed data.
   assign buf_free = !if_valid_reg || if_ready;
   // BOOT ignores control-flow changes: the PC is not yet meaningful there.
   assign flush    = (state_reg != BOOT) && (trap_valid || redirect_valid);

   // The address bus simply mirrors the PC; it only matters while imem_req
   // is high, and the PC does not move while a request waits for gnt.
   assign imem_addr = pc;

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      pc_en         = 1'b0;
      pc_next       = pc_plus4;
      imem_req      = 1'b0;
      if_valid_next = if_valid_reg;
      if_instr_next = if_instr_reg;
      if_pc_next    = if_pc_reg;
      req_pc_next   = req_pc_reg;

      // Default buffer drain; a load below in the same cycle takes precedence.
      if (consume) begin
         if_valid_next = 1'b0;
      end

      case (state_reg)
         BOOT: begin
            pc_en      = 1'b1;
            pc_next    = RESET_VEC;
            state_next = REQ;
         end

         REQ: begin
            // A request is never raised in a cycle that changes the PC,
            // otherwise the fetch address and the new PC would disagree.
            imem_req = buf_free && !redirect_valid && !trap_valid;
            if (imem_req && imem_gnt) begin
               pc_en       = 1'b1;
               pc_next     = pc_plus4;
               req_pc_next = pc;
               state_next  = WAIT;
            end
         end

         WAIT: begin
            if (imem_rvalid) begin
               if_instr_next = imem_rdata;
               if_pc_next    = req_pc_reg;
               if_valid_next = 1'b1;
               state_next    = REQ;
            end
         end

         KILL: begin
            // Wrong-path response: swallow it, leave the buffer alone.
            if (imem_rvalid) begin
               state_next = REQ;
            end
         end

         default: begin
            state_next = BOOT;
         end
      endcase

      // Redirect / trap overrides whatever the state logic decided for the
      // PC and the buffer.
      if (flush) begin
         pc_en         = 1'b1;
         pc_next       = trap_valid ? TRAP_VEC : redirect_target;
         if_valid_next = 1'b0;
         case (state_reg)
            // A response arriving in the same cycle retires the only
            // outstanding request, so nothing is left to kill.
            WAIT:    state_next = imem_rvalid ? REQ : KILL;
            // Same reasoning in KILL: if the stale response lands now,
            // waiting for another one would never end.
            KILL:    state_next = imem_rvalid ? REQ : KILL;
            default: state_next = REQ;
         endcase
      end

      // Keep the memory port and the PC quiet while reset is held.
      if (reset) begin
         pc_en    = 1'b0;
         imem_req = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= BOOT;
         if_valid_reg <= 1'b0;
         if_instr_reg <= 32'd0;
         if_pc_reg    <= 32'd0;
         req_pc_reg   <= 32'd0;
      end else begin
         state_reg    <= state_next;
         if_valid_reg <= if_valid_next;
         if_instr_reg <= if_instr_next;
         if_pc_reg    <= if_pc_next;
         req_pc_reg   <= req_pc_next;
      end
   end

   assign if_valid = if_valid_reg;
   assign if_instr = if_instr_reg;
   assign if_pc    = if_pc_reg;

endmodule
